// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: widths, register
// count and the fixed requester ids of the writeback sources.
package regfile_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 2**REG_IDX_W;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum int unsigned {
    REQ_ALU = 0,
    REQ_LSU = 1,
    REQ_WOS = 2
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// One-hot grant arbiter; round-robin by default, fixed lowest-index priority
// when REGFILE_ARB_FIXED_PRIO_EN is defined. Grant is forced low during reset.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  logic [N-1:0] gnt_raw;

`ifdef REGFILE_ARB_FIXED_PRIO_EN

  // Descending scan so the lowest requesting index is the last to overwrite.
  always_comb begin
    gnt_raw = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        gnt_raw        = '0;
        gnt_raw[i-1]   = 1'b1;
      end
    end
  end

`else

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Search begins one past the last winner and wraps modulo N.
  always_comb begin
    logic         found;
    int unsigned  idx;
    logic [N-1:0] sel;
    gnt_raw = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      sel = N'(1) << idx;
      if (!found && ((req & sel) != '0)) begin
        found   = 1'b1;
        gnt_raw = sel;
        ptr_d   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PW'(N - 1);
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

`endif

  assign gnt = rst ? '0 : gnt_raw;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ writeback requesters and
// keeps a per-register busy scoreboard. Option: REGFILE_ARB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned XLEN      = regfile_pkg::XLEN,
  parameter int unsigned REG_IDX_W = regfile_pkg::REG_IDX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*REG_IDX_W-1:0]   req_idx,
  input  logic [N_REQ*XLEN-1:0]        req_data,
  input  logic                         rsv_valid,
  input  logic [REG_IDX_W-1:0]         rsv_idx,
  output logic                         wr_en,
  output logic [REG_IDX_W-1:0]         wr_idx,
  output logic [XLEN-1:0]              wr_data,
  output logic [2**REG_IDX_W-1:0]      busy,
  output logic                         dbl_rsv_err
);

  localparam int unsigned NR = 2**REG_IDX_W;

  logic [N_REQ-1:0]     gnt;
  logic                 accept;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [XLEN-1:0]      sel_data;
  logic                 sel_nz;
  logic                 rsv_nz;

  logic                 wr_en_q,   wr_en_d;
  logic [REG_IDX_W-1:0] wr_idx_q,  wr_idx_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;
  logic [NR-1:0]        busy_q,    busy_d;
  logic                 dbl_q,     dbl_d;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = gnt;

  // Grant is one-hot and only asserted alongside valid, so it doubles as the accept mux select.
  always_comb begin
    accept   = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        accept   = 1'b1;
        sel_idx  = req_idx[i*REG_IDX_W +: REG_IDX_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_nz = (sel_idx != REG_IDX_W'(REG_ZERO));
  assign rsv_nz = (rsv_idx != REG_IDX_W'(REG_ZERO));

  // Clear is applied before set so a same-cycle reservation of the written register survives.
  always_comb begin
    wr_en_d   = accept && sel_nz;
    wr_idx_d  = sel_idx;
    wr_data_d = sel_data;
    busy_d    = busy_q;
    if (accept && sel_nz) begin
      busy_d[sel_idx] = 1'b0;
    end
    if (rsv_valid && rsv_nz) begin
      busy_d[rsv_idx] = 1'b1;
    end
    dbl_d = dbl_q;
    if (rsv_valid && rsv_nz && busy_q[rsv_idx] &&
        !(accept && (sel_idx == rsv_idx))) begin
      dbl_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      dbl_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      dbl_q     <= dbl_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_idx      = wr_idx_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign dbl_rsv_err = dbl_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a behavioural model of grants, writes and the busy map.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*5-1:0]  req_idx;
  logic [N*32-1:0] req_data;
  logic          rsv_valid;
  logic [4:0]    rsv_idx;
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [31:0]   wr_data;
  logic [31:0]   busy;
  logic          dbl_rsv_err;

  regfile_wb_arbiter #(
    .N_REQ     (N),
    .XLEN      (32),
    .REG_IDX_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_idx     (req_idx),
    .req_data    (req_data),
    .rsv_valid   (rsv_valid),
    .rsv_idx     (rsv_idx),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .busy        (busy),
    .dbl_rsv_err (dbl_rsv_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  expq[$];
  wr_t  e;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_dbl;
  int          last_g;
  logic [N-1:0] last_rdy;
  bit          pend[N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_en === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_spurious: got write idx %0d data %0h expected no write",
                 wr_idx, wr_data);
      end else begin
        e = expq.pop_front();
        check("wr_idx",   64'(wr_idx),  64'(e.idx));
        check("wr_data",  64'(wr_data), 64'(e.data));
        check("wr_cycle", 64'(cyc),     64'(e.cyc));
      end
    end
  end

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr  = N - 1;
    m_busy = '0;
    m_dbl  = 1'b0;
    expq.delete();
  endfunction

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic step();
    int          g;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [N-1:0] exp_rdy;
    #1;
    g        = model_grant();
    exp_rdy  = (g >= 0) ? N'(1 << g) : '0;
    last_rdy = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    idx  = '0;
    data = '0;
    if (g >= 0) begin
      idx   = req_idx[g*5 +: 5];
      data  = req_data[g*32 +: 32];
      m_ptr = g;
      if (idx != 5'd0) expq.push_back('{cyc + 1, idx, data});
    end
    if (rsv_valid && rsv_idx != 5'd0 && m_busy[rsv_idx] && !(g >= 0 && idx == rsv_idx))
      m_dbl = 1'b1;
    if (g >= 0 && idx != 5'd0) m_busy[idx] = 1'b0;
    if (rsv_valid && rsv_idx != 5'd0) m_busy[rsv_idx] = 1'b1;
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    check("busy",        64'(busy),        64'(m_busy));
    check("dbl_rsv_err", 64'(dbl_rsv_err), 64'(m_dbl));
  endtask

  task automatic reserve(input logic [4:0] r);
    rsv_valid = 1'b1;
    rsv_idx   = r;
    step();
    rsv_valid = 1'b0;
    rsv_idx   = '0;
  endtask

  int order[4] = '{0, 1, 2, 0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_idx   = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_idx   = '0;
    last_g    = -1;
    last_rdy  = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state, with requests asserted to show ready is held low
    req_valid = 3'b111;
    #1;
    check("rst_ready",   64'(req_ready),   64'(0));
    check("rst_wr_en",   64'(wr_en),       64'(0));
    check("rst_wr_idx",  64'(wr_idx),      64'(0));
    check("rst_wr_data", 64'(wr_data),     64'(0));
    check("rst_busy",    64'(busy),        64'(0));
    check("rst_dbl",     64'(dbl_rsv_err), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    repeat (10) step();
    check("idle_wr_en", 64'(wr_en), 64'(0));

    // Round-robin with all three requesters continuously valid
    reserve(5'd5);
    reserve(5'd6);
    reserve(5'd7);
    for (int i = 0; i < N; i++) begin
      req_idx[i*5 +: 5]   = 5'(5 + i);
      req_data[i*32 +: 32] = $urandom;
    end
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_order", 64'(last_rdy), 64'(1 << order[k]));
      if (last_g >= 0) req_data[last_g*32 +: 32] = $urandom;
    end
    req_valid = '0;
    step();
    check("busy_5_7_clear", 64'(busy[7:5]), 64'(0));

    // Write to x0: accepted but never reaches the register file
    req_idx[1*5 +: 5]    = 5'd0;
    req_data[1*32 +: 32] = 32'hDEADBEEF;
    req_valid = 3'b010;
    step();
    check("x0_ready", 64'(last_rdy), 64'(3'b010));
    check("x0_wr_en", 64'(wr_en),    64'(0));
    req_valid = '0;
    step();

    // Same-cycle reserve and write of x9: set wins, no double-reserve error
    reserve(5'd9);
    req_idx[2*5 +: 5]    = 5'd9;
    req_data[2*32 +: 32] = $urandom;
    req_valid = 3'b100;
    rsv_valid = 1'b1;
    rsv_idx   = 5'd9;
    step();
    req_valid = '0;
    rsv_valid = 1'b0;
    check("x9_busy", 64'(busy[9]),     64'(1));
    check("x9_dbl",  64'(dbl_rsv_err), 64'(0));
    step();

    // Double reservation of x3 is sticky
    reserve(5'd3);
    reserve(5'd3);
    check("x3_dbl", 64'(dbl_rsv_err), 64'(1));
    repeat (3) step();
    check("x3_dbl_sticky", 64'(dbl_rsv_err), 64'(1));

    // Random traffic
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          req_idx[i*5 +: 5]    = ($urandom % 2 == 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, 31));
          req_data[i*32 +: 32] = $urandom;
        end
      end
      for (int i = 0; i < N; i++) req_valid[i] = pend[i];
      rsv_valid = ($urandom % 3 == 0);
      rsv_idx   = 5'($urandom_range(0, 15));
      step();
      if (last_g >= 0) pend[last_g] = 1'b0;
    end
    req_valid = '0;
    rsv_valid = 1'b0;
    repeat (3) step();

    // Clean reset, then asynchronous reset with a write in flight
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    reserve(5'd4);
    reserve(5'd5);
    reserve(5'd6);
    reserve(5'd7);
    req_idx[0*5 +: 5]    = 5'd20;
    req_data[0*32 +: 32] = $urandom;
    req_valid = 3'b001;
    step();
    check("pre_rst_wr_en", 64'(wr_en), 64'(1));
    for (int i = 0; i < N; i++) begin
      req_idx[i*5 +: 5]    = 5'(10 + i);
      req_data[i*32 +: 32] = $urandom;
    end
    req_valid = 3'b111;
    #2;
    check("pre_rst_busy", 64'(busy), 64'(32'h0000_00F0));
    rst = 1'b1;
    #1;
    check("async_busy",  64'(busy),      64'(0));
    check("async_wr_en", 64'(wr_en),     64'(0));
    check("async_ready", 64'(req_ready), 64'(0));
    check("async_dbl",   64'(dbl_rsv_err), 64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_first", 64'(last_rdy), 64'(3'b001));
    step();
    check("post_rst_second", 64'(last_rdy), 64'(3'b010));
    req_valid = '0;
    repeat (3) step();

    check("pending_writes", 64'(expq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between N_REQ writeback requesters, such as the ALU, the load unit and the WOS filter unit. Arbitration is round-robin with a valid/ready handshake per requester. The winning write is registered onto the write port. A busy scoreboard tracks one pending bit per architectural register, so issue logic can detect RAW/WAW hazards.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
REG_IDX_W, 5, register index width (32 registers, x0 hardwired zero)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  requester i has a write pending
req_ready  out  N_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i]
req_idx  in  N_REQ*REG_IDX_W  packed destination indices, requester i at [i*5 +: 5]
req_data  in  N_REQ*XLEN  packed write data, requester i at [i*32 +: 32]
rsv_valid  in  1  issue stage reserves a destination register
rsv_idx  in  REG_IDX_W  register being reserved
wr_en  out  1  register file write enable
wr_idx  out  REG_IDX_W  register file write index
wr_data  out  XLEN  register file write data
busy  out  2**REG_IDX_W  scoreboard; bit r = write to xr outstanding
dbl_rsv_err  out  1  sticky; set when an already-busy register is reserved

Behaviour:
- Reset (asynchronous, rst=1): wr_en=0, wr_idx=0, wr_data=0, busy=0, dbl_rsv_err=0, rr pointer=N_REQ-1 (requester 0 has highest priority on the first arbitration).
- Reset mid-operation drops all pending bits and any in-flight write. req_ready is forced 0 while rst=1.
- req_ready is combinational from req_valid and the rr pointer. At most one bit is set; it is set only when the matching req_valid bit is 1.
- Round-robin: search starts at pointer+1 modulo N_REQ. On accept, pointer := granted index. With no valid requests, the pointer holds.
- Requesters hold req_idx/req_data stable while valid && !ready. req_valid may not be withdrawn before acceptance.
- Latency: an accept in cycle n drives wr_en=1 with that idx/data in cycle n+1. The register file samples on the falling edge within n+1. Output registers update every cycle: wr_en=0 when there is no accept.
- One write per cycle. Back-to-back accepts on consecutive cycles give continuous wr_en=1.
- Writes to x0: accepted (ready pulses), but wr_en stays 0 and busy is untouched.
- Scoreboard:
  - rsv_valid with rsv_idx!=0 sets busy[rsv_idx] next cycle.
  - An accepted write clears busy[req_idx] next cycle.
  - Same index reserved and written in the same cycle: set wins, so the bit stays 1 and the new reservation holds.
  - rsv_idx=0 is ignored.
  - Writing a non-busy register is legal and leaves the bit 0.
- dbl_rsv_err: set when rsv_valid && busy[rsv_idx] && no same-cycle clear of that index. Cleared only by reset.

Optional Feature:
REGFILE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest requester index wins. The rr pointer logic is removed. Higher-index requesters may starve, which is acceptable when requester 0 is the in-order pipeline.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package regfile_pkg:
  - XLEN
  - REG_IDX_W
  - NUM_REGS=2**REG_IDX_W
  - REG_ZERO=5'd0
  - requester ids REQ_ALU=0, REQ_LSU=1, REQ_WOS=2
- One sub-module, rr_arbiter: parameter N. Inputs are clk, rst, req[N] and advance. Output is a one-hot gnt[N]. It holds the pointer and the fixed-priority compile option.
- The scoreboard and output registers stay in the top.

Test Plan:
- Reset release, idle: all outputs 0, busy=0, rr pointer=N_REQ-1; no wr_en for 10 cycles.
- All three requesters valid continuously:
  - rsv x5/x6/x7 first.
  - Grants must be 0,1,2,0 on consecutive cycles.
  - wr_idx one cycle later matches each granted req_idx.
  - busy[5..7] clear one cycle after each accept.
- Write to x0 with data 0xDEADBEEF: ready=1, next cycle wr_en=0, busy unchanged.
- Same-cycle rsv_idx=9 and accepted write to x9: busy[9]=1 afterwards and dbl_rsv_err stays 0.
- Reserve x3 twice without a write: dbl_rsv_err=1 from the cycle after the second reserve, sticky until rst.
- Assert rst while req_valid=3'b111 and busy=0x0000_00F0: busy=0, wr_en=0 and req_ready=0 immediately (asynchronous). After release, requester 0 is granted first.
